scan_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with a registered output and two modes: manual (channel chosen by `Sel`) and auto-scan (internal pointer steps through all channels, dwelling DWELL cycles on each). It generalises the 4:1 combinational multiplexer into a clocked front-end selector. It feeds display and observation logic that needs either a fixed channel or a round-robin sweep, with a frame-complete strobe.

---
 rtl/scan_mux_pkg.sv | 15 +
 rtl/scan_ctr.sv | 74 +++++++
 rtl/scan_mux.sv | 71 +++++++
 tb/tb_scan_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared definitions for the scan_mux channel selector.
//   mode_e      : manual / scan mode encoding (MODE_MANUAL = 0, MODE_SCAN = 1)
//   safe_clog2  : max(1, clog2(x)), used to size select and counter fields
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic int safe_clog2(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/scan_ctr.sv
// scan_ctr: channel pointer, dwell counter and frame strobe for scan_mux.
//   clk, reset : clock, synchronous active-high reset
//   sel        : start / manual channel (already range-checked by the caller)
//   mode       : 0 = manual, 1 = scan
//   hold       : freezes pointer and dwell counter in steady scan
//   ptr        : registered channel pointer
//   ptr_next   : value ptr takes at the next edge (used to register the data)
//   frame      : one-cycle pulse on the N-1 -> 0 wrap
module scan_ctr
    import scan_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = safe_clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] sel,
    input  logic          mode,
    input  logic          hold,
    output logic [SW-1:0] ptr,
    output logic [SW-1:0] ptr_next,
    output logic          frame
);

    localparam int              CW       = safe_clog2(DWELL);
    localparam logic [SW-1:0]   PTR_LAST = SW'(N - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    mode_e         mode_q;
    mode_e         mode_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          frame_next;

    always_comb begin
        mode_d     = mode_e'(mode);
        ptr_next   = ptr;
        cnt_next   = cnt;
        frame_next = 1'b0;
        if (mode_d == MODE_MANUAL || mode_q == MODE_MANUAL) begin
            // manual, or first scan cycle: load from sel; this cycle is dwell #1
            ptr_next = sel;
            cnt_next = '0;
        end else if (!hold) begin
            if (cnt == CNT_LAST) begin
                cnt_next = '0;
                if (ptr == PTR_LAST) begin
                    ptr_next   = '0;
                    frame_next = 1'b1;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            cnt    <= '0;
            mode_q <= MODE_MANUAL;
            frame  <= 1'b0;
        end else begin
            ptr    <= ptr_next;
            cnt    <= cnt_next;
            mode_q <= mode_d;
            frame  <= frame_next;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: N-channel WIDTH-bit selector with registered output, manual
// and round-robin scan modes.
//   clk, reset : clock, synchronous active-high reset
//   In         : packed channels, channel k = In[k*WIDTH +: WIDTH]
//   Sel        : manual channel / scan start channel (>= N treated as 0)
//   Mode       : 0 = manual, 1 = scan
//   Hold       : scan only, freezes the sweep
//   Out        : registered data of channel Ch
//   Ch         : channel index Out was taken from
//   Frame      : one-cycle pulse when the sweep wraps to channel 0
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = safe_clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   In,
    input  logic [SW-1:0]        Sel,
    input  logic                 Mode,
    input  logic                 Hold,
    output logic [WIDTH-1:0]     Out,
    output logic [SW-1:0]        Ch,
    output logic                 Frame
);

    logic [SW-1:0]    sel_eff;
    logic [SW-1:0]    ptr_next;
    logic [WIDTH-1:0] chan [N];

    // only non-power-of-two N can present an out-of-range select
    generate
        if (N < (1 << SW)) begin : g_sel_clip
            always_comb sel_eff = (Sel < SW'(N)) ? Sel : '0;
        end else begin : g_sel_pass
            always_comb sel_eff = Sel;
        end
    endgenerate

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            chan[k] = In[k*WIDTH +: WIDTH];
        end
    end

    scan_ctr #(
        .N     (N),
        .DWELL (DWELL)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel_eff),
        .mode     (Mode),
        .hold     (Hold),
        .ptr      (Ch),
        .ptr_next (ptr_next),
        .frame    (Frame)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Out <= '0;
        end else begin
            Out <= chan[ptr_next];
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed self-checking bench for scan_mux.
//   dut_a : WIDTH=4, N=4, DWELL=3  (reset, manual, sweep, hold, reset mid-scan)
//   dut_b : WIDTH=4, N=3, DWELL=1  (out-of-range select, fast sweep)
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] a_in;
    logic [1:0]  a_sel;
    logic        a_mode;
    logic        a_hold;
    logic [3:0]  a_out;
    logic [1:0]  a_ch;
    logic        a_frame;

    logic [11:0] b_in;
    logic [1:0]  b_sel;
    logic        b_mode;
    logic        b_hold;
    logic [3:0]  b_out;
    logic [1:0]  b_ch;
    logic        b_frame;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(4), .N(4), .DWELL(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .In    (a_in),
        .Sel   (a_sel),
        .Mode  (a_mode),
        .Hold  (a_hold),
        .Out   (a_out),
        .Ch    (a_ch),
        .Frame (a_frame)
    );

    scan_mux #(.WIDTH(4), .N(3), .DWELL(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .In    (b_in),
        .Sel   (b_sel),
        .Mode  (b_mode),
        .Hold  (b_hold),
        .Out   (b_out),
        .Ch    (b_ch),
        .Frame (b_frame)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input int ch, input int out, input int frame);
        check({tag, ".ch"},    32'(a_ch),    32'(ch));
        check({tag, ".out"},   32'(a_out),   32'(out));
        check({tag, ".frame"}, 32'(a_frame), 32'(frame));
    endtask

    task automatic expect_b(input string tag, input int ch, input int out, input int frame);
        check({tag, ".ch"},    32'(b_ch),    32'(ch));
        check({tag, ".out"},   32'(b_out),   32'(out));
        check({tag, ".frame"}, 32'(b_frame), 32'(frame));
    endtask

    // channel data for In = 16'h8421: ch0=1 ch1=2 ch2=4 ch3=8
    function automatic int a_data(input int ch);
        return 1 << ch;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int sweep_ch [13] = '{1,1,1,2,2,2,3,3,3,0,0,0,1};
        int sweep_fr [13] = '{0,0,0,0,0,0,0,0,0,1,0,0,0};

        // reset with busy inputs
        reset  = 1'b1;
        a_in   = 16'hFFFF;
        a_sel  = 2'd3;
        a_mode = 1'b1;
        a_hold = 1'b0;
        b_in   = 12'hFFF;
        b_sel  = 2'd2;
        b_mode = 1'b1;
        b_hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            expect_a("reset_a", 0, 0, 0);
            expect_b("reset_b", 0, 0, 0);
        end

        // manual selection
        reset  = 1'b0;
        a_in   = 16'h8421;
        a_mode = 1'b0;
        a_sel  = 2'd2;
        b_mode = 1'b0;
        b_in   = 12'h421;
        b_sel  = 2'd0;
        step();
        expect_a("manual_sel2", 2, 4'h4, 0);
        a_sel = 2'd3;
        step();
        expect_a("manual_sel3", 3, 4'h8, 0);

        // scan sweep from channel 1
        a_sel  = 2'd1;
        a_mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            expect_a($sformatf("sweep%0d", i), sweep_ch[i], a_data(sweep_ch[i]), sweep_fr[i]);
        end

        // advance to the second cycle of channel 2, then hold
        begin
            int pre [4] = '{1,1,2,2};
            for (int i = 0; i < 4; i++) begin
                step();
                expect_a($sformatf("pre_hold%0d", i), pre[i], a_data(pre[i]), 0);
            end
        end
        a_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_a($sformatf("hold%0d", i), 2, 4'h4, 0);
        end
        a_hold = 1'b0;
        step();
        expect_a("hold_resume", 2, 4'h4, 0);
        step();
        expect_a("hold_next", 3, 4'h8, 0);
        step();
        expect_a("to_wrap0", 3, 4'h8, 0);
        step();
        expect_a("to_wrap1", 3, 4'h8, 0);

        // hold across the wrap point: frame only when the wrap really happens
        a_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_a($sformatf("hold_wrap%0d", i), 3, 4'h8, 0);
        end
        a_hold = 1'b0;
        step();
        expect_a("wrap_after_hold", 0, 4'h1, 1);
        step();
        expect_a("wrap_after_hold_next", 0, 4'h1, 0);

        // walk to channel 2, then reset mid-scan with Sel=3
        begin
            int pre [5] = '{0,1,1,1,2};
            for (int i = 0; i < 5; i++) begin
                step();
                expect_a($sformatf("pre_reset%0d", i), pre[i], a_data(pre[i]), 0);
            end
        end
        a_sel = 2'd3;
        reset = 1'b1;
        step();
        expect_a("mid_reset", 0, 0, 0);
        reset = 1'b0;
        step();
        expect_a("post_reset_entry", 3, 4'h8, 0);
        step();
        expect_a("post_reset_dwell1", 3, 4'h8, 0);
        step();
        expect_a("post_reset_dwell2", 3, 4'h8, 0);
        step();
        expect_a("post_reset_wrap", 0, 4'h1, 1);

        // mode toggling every cycle reloads from Sel and never advances
        a_sel = 2'd1;
        for (int i = 0; i < 4; i++) begin
            a_mode = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            expect_a($sformatf("toggle%0d", i), 1, 4'h2, 0);
        end

        // N=3, DWELL=1: out-of-range manual select falls back to channel 0
        b_sel  = 2'd2;
        b_mode = 1'b0;
        step();
        expect_b("b_manual2", 2, 4'h4, 0);
        b_sel = 2'd3;
        step();
        expect_b("b_manual3", 0, 4'h1, 0);

        // scan from 0: no frame on entry, frame every third cycle from cycle 4
        b_sel  = 2'd0;
        b_mode = 1'b1;
        begin
            int bch [7] = '{0,1,2,0,1,2,0};
            int bfr [7] = '{0,0,0,1,0,0,1};
            for (int i = 0; i < 7; i++) begin
                step();
                expect_b($sformatf("b_scan%0d", i + 1), bch[i], 1 << bch[i], bfr[i]);
            end
        end

        // hold in the fast sweep; then scan entry from an out-of-range Sel
        b_hold = 1'b1;
        step();
        expect_b("b_hold", 0, 4'h1, 0);
        b_hold = 1'b0;
        step();
        expect_b("b_hold_release", 1, 4'h2, 0);
        b_mode = 1'b0;
        b_sel  = 2'd3;
        step();
        expect_b("b_back_manual", 0, 4'h1, 0);
        b_mode = 1'b1;
        step();
        expect_b("b_entry_clip", 0, 4'h1, 0);
        step();
        expect_b("b_entry_next", 1, 4'h2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
